pipeline_mem_arbiter: RTL



---
 rtl/pipeline_mem_arbiter_if.sv | 46 ++++
 rtl/pipeline_mem_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory arbiter.
// slave = arbiter view; master = the mirror view held by the stages and memory.
interface pipeline_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic                  d_indirect;
    logic                  d_byte;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_byte_enable;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_indirect, d_byte, d_addr, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_indirect, d_byte, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store, including two-access LDI/STI.
// Latency: strobe one cycle after a request is seen; resp pulses combinationally with mem_resp.
// Backpressure: strobes held until mem_resp; requesters hold requests until their resp.
// Optional MEM_ARB_FAIR_EN: alternate grants when both sides are pending (default data first).
module pipeline_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pipeline_mem_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_ACC,
        S_D_ACC,
        S_D_PTR,
        S_D_IND
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_wr;
`ifdef MEM_ARB_FAIR_EN
    logic                  r_last_d;
`endif

    logic                  w_d_req;
    logic                  w_grant_d;
    logic [ADDR_WIDTH-1:0] w_fin_addr;
    logic [1:0]            w_byte_be;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic [ADDR_WIDTH-1:0] w_mem_address;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [1:0]            w_mem_be;
    logic                  w_i_resp;
    logic                  w_d_resp;

    assign w_d_req = bus.d_read | bus.d_write;

    always_comb begin
`ifdef MEM_ARB_FAIR_EN
        w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
`else
        w_grant_d = w_d_req;
`endif
    end

    // The read/write choice is latched at grant so a flushed request still completes cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_wr     <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            r_last_d <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state <= bus.d_indirect ? S_D_PTR : S_D_ACC;
                        r_wr    <= bus.d_write & ~bus.d_read;
`ifdef MEM_ARB_FAIR_EN
                        r_last_d <= 1'b1;
`endif
                    end else if (bus.i_read) begin
                        r_state <= S_I_ACC;
                        r_wr    <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
                        r_last_d <= 1'b0;
`endif
                    end
                end
                S_I_ACC, S_D_ACC, S_D_IND: begin
                    if (bus.mem_resp) r_state <= S_IDLE;
                end
                S_D_PTR: begin
                    if (bus.mem_resp) begin
                        r_ptr   <= ADDR_WIDTH'(bus.mem_rdata);
                        r_state <= S_D_IND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_fin_addr = (r_state == S_D_IND) ? r_ptr : bus.d_addr;
    assign w_byte_be  = !bus.d_byte ? 2'b11 : (w_fin_addr[0] ? 2'b10 : 2'b01);

    always_comb begin
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_address = '0;
        w_mem_wdata   = '0;
        w_mem_be      = 2'b00;
        case (r_state)
            S_I_ACC: begin
                w_mem_read    = 1'b1;
                w_mem_address = bus.i_addr;
                w_mem_be      = 2'b11;
            end
            S_D_PTR: begin
                w_mem_read    = 1'b1;
                w_mem_address = bus.d_addr;
                w_mem_be      = 2'b11;
            end
            S_D_ACC, S_D_IND: begin
                w_mem_read    = ~r_wr;
                w_mem_write   = r_wr;
                w_mem_address = w_fin_addr;
                w_mem_wdata   = bus.d_wdata;
                w_mem_be      = w_byte_be;
            end
            default: ;
        endcase
    end

    assign w_i_resp = (r_state == S_I_ACC) & bus.mem_resp;
    assign w_d_resp = ((r_state == S_D_ACC) | (r_state == S_D_IND)) & bus.mem_resp;

    assign bus.mem_read        = w_mem_read;
    assign bus.mem_write       = w_mem_write;
    assign bus.mem_address     = w_mem_address;
    assign bus.mem_wdata       = w_mem_wdata;
    assign bus.mem_byte_enable = w_mem_be;
    assign bus.i_resp          = w_i_resp;
    assign bus.i_rdata         = w_i_resp ? bus.mem_rdata : '0;
    assign bus.d_resp          = w_d_resp;
    assign bus.d_rdata         = w_d_resp ? bus.mem_rdata : '0;

endmodule
